vent_humidity_ctrl: RTL and testbench
=====================================

Name: vent_humidity_ctrl

Overview:
- Closed-loop controller for the extract-fan PWM channel.
- Consumes 40-bit frames from the humidity sensor reader and validates the checksum.
- Applies SPI-written thresholds with hysteresis and a minimum on-time, then ramps the duty command fed to the vent PWM channel.
- Sits between the Humidity/SPI_slave outputs and the PWM block's vent channel.

Parameters:
TICK_DIV, 1000, clk1M cycles per ramp tick (1 ms)
RAMP_STEP, 1, duty units added/removed per tick
MIN_ON_TICKS, 30000, minimum ticks in non-IDLE before an auto demand drop is honoured

Ports:
clk1M  in  1  system clock, 1 MHz
rst_n  in  1  asynchronous active-low reset
hym_frame  in  40  {hum_int[39:32], hum_dec[31:24], t_int[23:16], t_dec[15:8], csum[7:0]}
frame_stb  in  1  one-cycle pulse: hym_frame is new and stable
cfg_on_thr  in  8  humidity % at or above which auto demand asserts
cfg_off_thr  in  8  humidity % below which auto demand deasserts
cfg_duty_max  in  8  target duty while running
cfg_mode  in  2  00/11 auto, 01 force off, 10 force on
duty_out  out  8  duty command to vent PWM
vent_on  out  1  high in any state except IDLE
hum_valid  out  1  last frame passed checksum
hum_pct  out  8  last valid hum_int
err_cnt  out  8  bad-frame count, saturates at 255
cfg_err  out  1  cfg_off_thr >= cfg_on_thr
state_out  out  2  IDLE=0, RAMP_UP=1, RUN=2, RAMP_DOWN=3

Behaviour:
- Reset (async, rst_n low):
  - All outputs 0; state IDLE; prescaler, min-on counter and demand are 0.
  - Reset mid-ramp forces duty_out to 0 immediately.
- Checksum:
  - Frame is good when (b4+b3+b2+b1) mod 256 == b0.
  - Evaluated on frame_stb at edge N; results visible at N+1.
  - Good frame: hum_pct <= hum_int, hum_valid <= 1.
  - Bad frame: hum_valid <= 0, err_cnt += 1 (saturating at 255), hum_pct held.
- Tick:
  - Free-running prescaler counts 0..TICK_DIV-1; tick is a one-cycle pulse at the wrap.
  - The prescaler is never reset by mode or state changes.
- Demand (registered, updates at N+2 relative to frame_stb; updates on the next cycle for cfg changes):
  - force on -> 1.
  - force off -> 0.
  - auto, cfg_err=1 -> 0.
  - auto, good data:
    - hum_pct >= cfg_on_thr -> 1.
    - hum_pct < cfg_off_thr -> 0.
    - Between the thresholds -> hold.
  - auto, hum_valid=0 -> hold (fail-hold).
- FSM, evaluated every cycle; duty changes only on tick:
  - IDLE:
    - duty 0.
    - demand=1 -> RAMP_UP; load min-on counter with MIN_ON_TICKS.
  - RAMP_UP:
    - On tick, duty <= min(duty+RAMP_STEP, cfg_duty_max).
    - duty == cfg_duty_max -> RUN, also when cfg_duty_max = 0 (same cycle, no tick needed).
  - RUN:
    - On tick, slew duty one RAMP_STEP toward cfg_duty_max, clamped so it never overshoots.
  - RAMP_DOWN:
    - On tick, duty <= max(duty-RAMP_STEP, 0).
    - duty == 0 -> IDLE.
    - demand=1 -> RAMP_UP from current duty; min-on counter is not reloaded.
  - Exit from RAMP_UP/RUN to RAMP_DOWN:
    - Taken when demand=0 and (min-on counter == 0 or cfg_mode == force off).
    - Force off bypasses min-on immediately.
- Min-on counter:
  - Decrements on tick while not IDLE; stops at 0.
- Arithmetic:
  - All duty math uses 9-bit intermediates; no wrap-around at 0 or 255.
- Simultaneous events:
  - frame_stb on the same edge as tick: the checksum latch and the duty step both occur.
  - The new demand affects the FSM one cycle later.
- Outputs:
  - vent_on = (state != IDLE), registered together with state.

Test Plan:
- Reset with rst_n low mid-RAMP_UP at duty 40 -> duty_out=0, state_out=0 asynchronously; err_cnt=0.
- Auto, on=70, off=60, duty_max=10, TICK_DIV=4: good frame hum 75 (csum ok) -> RAMP_UP 2 cycles after frame_stb, duty 1..10 every 4 cycles, then RUN.
- Hysteresis/min-on with MIN_ON_TICKS=20:
  - Frame hum 65 -> stays RUN.
  - Frame hum 55 at tick 5 -> stays RUN until min-on reaches 0, then RAMP_DOWN to 0 and IDLE.
- Bad checksum frame (csum off by 1) while RUN -> hum_valid=0, err_cnt=1, hum_pct unchanged, state unchanged.
- 300 bad frames -> err_cnt=255.
- cfg_mode=01 during RUN at tick 2 of min-on -> RAMP_DOWN next cycle.
- Switch to 10 mid-RAMP_DOWN at duty 5 -> RAMP_UP continuing from 5.
- cfg_off_thr=80, cfg_on_thr=70, auto, hum 90 -> cfg_err=1, demand 0, stays IDLE.
- cfg_duty_max=0, force on -> RUN with duty 0 and vent_on=1.

Source files
------------

// File: rtl/vent_humidity_ctrl.sv
// Extract-fan humidity controller: validates sensor frames, derives fan demand
// with hysteresis and a minimum on-time, and ramps the vent PWM duty command.
module vent_humidity_ctrl #(
    parameter int unsigned TICK_DIV     = 1000,
    parameter int unsigned RAMP_STEP    = 1,
    parameter int unsigned MIN_ON_TICKS = 30000
) (
    input  logic        clk1M,
    input  logic        rst_n,
    input  logic [39:0] hym_frame,
    input  logic        frame_stb,
    input  logic [7:0]  cfg_on_thr,
    input  logic [7:0]  cfg_off_thr,
    input  logic [7:0]  cfg_duty_max,
    input  logic [1:0]  cfg_mode,
    output logic [7:0]  duty_out,
    output logic        vent_on,
    output logic        hum_valid,
    output logic [7:0]  hum_pct,
    output logic [7:0]  err_cnt,
    output logic        cfg_err,
    output logic [1:0]  state_out
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned MON_W = (MIN_ON_TICKS > 0) ? $clog2(MIN_ON_TICKS + 1) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [MON_W-1:0] MON_LOAD = MON_W'(MIN_ON_TICKS);
    localparam logic [8:0]       STEP9    = 9'(RAMP_STEP);

    localparam logic [1:0] MODE_OFF = 2'b01;
    localparam logic [1:0] MODE_ON  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RAMP_UP   = 2'd1,
        S_RUN       = 2'd2,
        S_RAMP_DOWN = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [7:0]       duty_nxt;
    logic [MON_W-1:0] min_on, min_on_nxt;
    logic [PRE_W-1:0] presc;
    logic             tick_c;
    logic             demand, demand_nxt_c;
    logic             cfg_err_c;
    logic [7:0]       csum_c;
    logic             frame_ok_c;
    logic             leave_c;
    logic [8:0]       up9_c, dn9_c;
    logic [7:0]       up_c, dn_c, down_to_max_c;

    // Checksum over the four payload bytes, modulo 256
    assign csum_c     = hym_frame[39:32] + hym_frame[31:24] + hym_frame[23:16] + hym_frame[15:8];
    assign frame_ok_c = (csum_c == hym_frame[7:0]);

    always_ff @(posedge clk1M or negedge rst_n) begin
        if (!rst_n) begin
            hum_valid <= 1'b0;
            hum_pct   <= 8'd0;
            err_cnt   <= 8'd0;
        end else if (frame_stb) begin
            if (frame_ok_c) begin
                hum_valid <= 1'b1;
                hum_pct   <= hym_frame[39:32];
            end else begin
                hum_valid <= 1'b0;
                if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end
        end
    end

    // Free-running ramp prescaler; tick marks the wrap cycle
    assign tick_c = (presc == PRE_LAST);

    always_ff @(posedge clk1M or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (tick_c) begin
            presc <= '0;
        end else begin
            presc <= presc + PRE_W'(1);
        end
    end

    assign cfg_err_c = (cfg_off_thr >= cfg_on_thr);

    // Demand: forced modes win, inverted thresholds kill auto, stale data holds
    always_comb begin
        demand_nxt_c = demand;
        if (cfg_mode == MODE_ON) begin
            demand_nxt_c = 1'b1;
        end else if (cfg_mode == MODE_OFF) begin
            demand_nxt_c = 1'b0;
        end else if (cfg_err_c) begin
            demand_nxt_c = 1'b0;
        end else if (hum_valid) begin
            if (hum_pct >= cfg_on_thr) begin
                demand_nxt_c = 1'b1;
            end else if (hum_pct < cfg_off_thr) begin
                demand_nxt_c = 1'b0;
            end
        end
    end

    always_ff @(posedge clk1M or negedge rst_n) begin
        if (!rst_n) begin
            demand  <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            demand  <= demand_nxt_c;
            cfg_err <= cfg_err_c;
        end
    end

    // 9-bit duty arithmetic; dn9_c[8] flags a borrow below zero
    assign up9_c = {1'b0, duty_out} + STEP9;
    assign dn9_c = {1'b0, duty_out} - STEP9;
    assign up_c  = (up9_c >= {1'b0, cfg_duty_max}) ? cfg_duty_max : up9_c[7:0];
    assign dn_c  = dn9_c[8] ? 8'd0 : dn9_c[7:0];
    assign down_to_max_c = (dn9_c[8] || (dn9_c[7:0] < cfg_duty_max)) ? cfg_duty_max : dn9_c[7:0];

    assign leave_c = !demand && ((min_on == '0) || (cfg_mode == MODE_OFF));

    always_comb begin
        state_nxt  = state;
        duty_nxt   = duty_out;
        min_on_nxt = min_on;
        if (tick_c && (state != S_IDLE) && (min_on != '0)) begin
            min_on_nxt = min_on - MON_W'(1);
        end
        case (state)
            S_IDLE: begin
                duty_nxt = 8'd0;
                if (demand) begin
                    state_nxt  = S_RAMP_UP;
                    min_on_nxt = MON_LOAD;
                end
            end
            S_RAMP_UP: begin
                if (leave_c) begin
                    state_nxt = S_RAMP_DOWN;
                end else if (duty_out == cfg_duty_max) begin
                    state_nxt = S_RUN;
                end else if (tick_c) begin
                    duty_nxt = up_c;
                end
            end
            S_RUN: begin
                if (leave_c) begin
                    state_nxt = S_RAMP_DOWN;
                end else if (tick_c) begin
                    duty_nxt = (duty_out < cfg_duty_max) ? up_c : down_to_max_c;
                end
            end
            S_RAMP_DOWN: begin
                if (duty_out == 8'd0) begin
                    state_nxt = S_IDLE;
                end else if (demand) begin
                    state_nxt = S_RAMP_UP;
                end else if (tick_c) begin
                    duty_nxt = dn_c;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk1M or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            duty_out <= 8'd0;
            min_on   <= '0;
            vent_on  <= 1'b0;
        end else begin
            state    <= state_nxt;
            duty_out <= duty_nxt;
            min_on   <= min_on_nxt;
            vent_on  <= (state_nxt != S_IDLE);
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_vent_humidity_ctrl.sv
// Bench for vent_humidity_ctrl: integer reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_vent_humidity_ctrl;

    localparam int TICK_DIV     = 4;
    localparam int RAMP_STEP    = 1;
    localparam int MIN_ON_TICKS = 20;

    logic        clk1M = 1'b0;
    logic        rst_n = 1'b0;
    logic [39:0] hym_frame = '0;
    logic        frame_stb = 1'b0;
    logic [7:0]  cfg_on_thr = 8'd70;
    logic [7:0]  cfg_off_thr = 8'd60;
    logic [7:0]  cfg_duty_max = 8'd10;
    logic [1:0]  cfg_mode = 2'b00;
    logic [7:0]  duty_out;
    logic        vent_on;
    logic        hum_valid;
    logic [7:0]  hum_pct;
    logic [7:0]  err_cnt;
    logic        cfg_err;
    logic [1:0]  state_out;

    int n_checks = 0;
    int n_fail   = 0;

    vent_humidity_ctrl #(
        .TICK_DIV(TICK_DIV),
        .RAMP_STEP(RAMP_STEP),
        .MIN_ON_TICKS(MIN_ON_TICKS)
    ) dut (
        .clk1M(clk1M),
        .rst_n(rst_n),
        .hym_frame(hym_frame),
        .frame_stb(frame_stb),
        .cfg_on_thr(cfg_on_thr),
        .cfg_off_thr(cfg_off_thr),
        .cfg_duty_max(cfg_duty_max),
        .cfg_mode(cfg_mode),
        .duty_out(duty_out),
        .vent_on(vent_on),
        .hum_valid(hum_valid),
        .hum_pct(hum_pct),
        .err_cnt(err_cnt),
        .cfg_err(cfg_err),
        .state_out(state_out)
    );

    always #500 clk1M = ~clk1M;

    typedef struct packed {
        int presc;
        int st;
        int duty;
        int minon;
        bit dem;
        bit hv;
        int hp;
        int ec;
        bit cerr;
        bit von;
    } mdl_t;

    mdl_t m;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Reference: one clock of the controller using plain integer arithmetic
    function automatic mdl_t step(input mdl_t c, input logic stb, input logic [39:0] f,
                                  input logic [7:0] on, input logic [7:0] off,
                                  input logic [7:0] mx, input logic [1:0] mode);
        mdl_t n;
        bit tick, leave;
        int sum, mxi;
        n = c;
        tick = (c.presc == TICK_DIV - 1);
        n.presc = tick ? 0 : c.presc + 1;
        if (stb) begin
            sum = (int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8])) % 256;
            if (sum == int'(f[7:0])) begin
                n.hv = 1'b1;
                n.hp = int'(f[39:32]);
            end else begin
                n.hv = 1'b0;
                n.ec = imin(c.ec + 1, 255);
            end
        end
        n.cerr = (off >= on);
        if (mode == 2'b10) n.dem = 1'b1;
        else if (mode == 2'b01) n.dem = 1'b0;
        else if (off >= on) n.dem = 1'b0;
        else if (c.hv) begin
            if (c.hp >= int'(on)) n.dem = 1'b1;
            else if (c.hp < int'(off)) n.dem = 1'b0;
        end
        if (tick && c.st != 0) n.minon = imax(c.minon - 1, 0);
        mxi = int'(mx);
        leave = !c.dem && (c.minon == 0 || mode == 2'b01);
        case (c.st)
            0: begin
                n.duty = 0;
                if (c.dem) begin
                    n.st = 1;
                    n.minon = MIN_ON_TICKS;
                end
            end
            1: begin
                if (leave) n.st = 3;
                else if (c.duty == mxi) n.st = 2;
                else if (tick) n.duty = imin(c.duty + RAMP_STEP, mxi);
            end
            2: begin
                if (leave) n.st = 3;
                else if (tick) begin
                    if (c.duty < mxi) n.duty = imin(c.duty + RAMP_STEP, mxi);
                    else n.duty = imax(c.duty - RAMP_STEP, mxi);
                end
            end
            default: begin
                if (c.duty == 0) n.st = 0;
                else if (c.dem) n.st = 1;
                else if (tick) n.duty = imax(c.duty - RAMP_STEP, 0);
            end
        endcase
        n.von = (n.st != 0);
        return n;
    endfunction

    always @(posedge clk1M or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else m <= step(m, frame_stb, hym_frame, cfg_on_thr, cfg_off_thr, cfg_duty_max, cfg_mode);
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk1M) begin
        check("duty_out", int'(duty_out), m.duty);
        check("state_out", int'(state_out), m.st);
        check("vent_on", int'(vent_on), int'(m.von));
        check("hum_valid", int'(hum_valid), int'(m.hv));
        check("hum_pct", int'(hum_pct), m.hp);
        check("err_cnt", int'(err_cnt), m.ec);
        check("cfg_err", int'(cfg_err), int'(m.cerr));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk1M);
    endtask

    task automatic send_frame(input logic [7:0] hum, input bit bad);
        logic [7:0] cs;
        cs = hum + 8'd22 + 8'd5 + (bad ? 8'd1 : 8'd0);
        hym_frame = {hum, 8'd0, 8'd22, 8'd5, cs};
        frame_stb = 1'b1;
        @(negedge clk1M);
        frame_stb = 1'b0;
    endtask

    task automatic wait_state(input string name, input logic [1:0] s, input int budget);
        int k;
        k = 0;
        while (state_out != s && k < budget) begin
            @(negedge clk1M);
            k++;
        end
        check(name, int'(state_out), int'(s));
    endtask

    task automatic wait_duty(input string name, input logic [7:0] d, input int budget);
        int k;
        k = 0;
        while (duty_out != d && k < budget) begin
            @(negedge clk1M);
            k++;
        end
        check(name, int'(duty_out), int'(d));
    endtask

    initial begin
        cyc(3);
        check("rst_duty", int'(duty_out), 0);
        check("rst_state", int'(state_out), 0);
        check("rst_err_cnt", int'(err_cnt), 0);
        check("rst_hum_valid", int'(hum_valid), 0);
        rst_n = 1'b1;
        cyc(5);

        // Good frame hum 75 starts the fan two edges after the strobe edge
        send_frame(8'd75, 1'b0);
        check("f75_hum_valid", int'(hum_valid), 1);
        check("f75_hum_pct", int'(hum_pct), 75);
        cyc(1);
        check("f75_still_idle", int'(state_out), 0);
        cyc(1);
        check("f75_ramp_up", int'(state_out), 1);
        check("f75_vent_on", int'(vent_on), 1);
        wait_state("reach_run", 2'd2, 200);
        check("run_duty", int'(duty_out), 10);

        // Between thresholds holds; below off waits for min-on
        send_frame(8'd65, 1'b0);
        cyc(10);
        check("hyst_hold_run", int'(state_out), 2);
        send_frame(8'd55, 1'b0);
        cyc(3);
        check("minon_hold_run", int'(state_out), 2);
        wait_state("minon_ramp_down", 2'd3, 400);
        check("ramp_down_start_duty", int'(duty_out), 10);
        wait_state("back_idle", 2'd0, 200);
        check("idle_duty", int'(duty_out), 0);

        // Bad checksum while running
        send_frame(8'd75, 1'b0);
        wait_state("rerun", 2'd2, 200);
        send_frame(8'd75, 1'b1);
        check("bad_hum_valid", int'(hum_valid), 0);
        check("bad_err_cnt", int'(err_cnt), 1);
        check("bad_hum_pct", int'(hum_pct), 75);
        check("bad_state", int'(state_out), 2);

        // Force off bypasses min-on, then force on resumes from current duty
        cfg_mode = 2'b01;
        cyc(2);
        check("force_off_down", int'(state_out), 3);
        wait_duty("down_to5", 8'd5, 200);
        cfg_mode = 2'b10;
        cyc(2);
        check("force_on_up", int'(state_out), 1);
        check("force_on_duty5", int'(duty_out), 5);
        wait_state("force_on_run", 2'd2, 200);
        check("force_on_duty10", int'(duty_out), 10);

        // Error counter saturation
        for (int i = 0; i < 300; i++) begin
            send_frame(8'd75, 1'b1);
            @(negedge clk1M);
        end
        check("err_sat", int'(err_cnt), 255);
        check("err_sat_pct", int'(hum_pct), 75);

        // Inverted thresholds suppress auto demand
        cfg_mode = 2'b01;
        wait_state("off_idle", 2'd0, 200);
        cfg_off_thr = 8'd80;
        cfg_on_thr  = 8'd70;
        cfg_mode    = 2'b00;
        send_frame(8'd90, 1'b0);
        check("cfg_err_set", int'(cfg_err), 1);
        cyc(5);
        check("cfg_err_idle", int'(state_out), 0);

        // Zero duty_max under force on
        cfg_off_thr  = 8'd60;
        cfg_duty_max = 8'd0;
        cfg_mode     = 2'b10;
        wait_state("zero_max_run", 2'd2, 50);
        check("zero_max_duty", int'(duty_out), 0);
        check("zero_max_vent", int'(vent_on), 1);
        check("cfg_err_clr", int'(cfg_err), 0);

        // Asynchronous reset mid-ramp at duty 40
        cfg_mode = 2'b01;
        wait_state("pre_rst_idle", 2'd0, 50);
        cfg_duty_max = 8'd50;
        cfg_mode     = 2'b10;
        wait_state("pre_rst_up", 2'd1, 50);
        wait_duty("pre_rst_duty40", 8'd40, 400);
        #100;
        rst_n = 1'b0;
        #1;
        check("async_rst_duty", int'(duty_out), 0);
        check("async_rst_state", int'(state_out), 0);
        check("async_rst_vent", int'(vent_on), 0);
        check("async_rst_err", int'(err_cnt), 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
